// File: rtl/s2_share_pkg.sv
// s2_share_pkg: shared types and constants for the S2 cell share controller
package s2_share_pkg;
  localparam int NREQ = 4;
  typedef enum logic [1:0] {IDLE, GRANT, BURST} state_t;
  typedef logic [1:0] idx_t;
  localparam logic CELL_CLR_RST = 1'b1;
endpackage

// File: rtl/s2_share_ctrl_rr_pick.sv
// rr_pick: combinational round-robin picker, first eligible bit from ptr upward
module rr_pick
  import s2_share_pkg::*;
(
  input  logic [NREQ-1:0] req_eff,
  input  idx_t            ptr,
  output logic [NREQ-1:0] win,
  output idx_t            win_idx,
  output logic            any
);
  always_comb begin
    win_idx = ptr;
    any = |req_eff;
    // scan farthest first so the nearest eligible bit overrides
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_eff[ptr + idx_t'(k)]) win_idx = ptr + idx_t'(k);
    win = any ? ({{(NREQ-1){1'b0}}, 1'b1} << win_idx) : '0;
  end
endmodule

// File: rtl/s2_share_ctrl.sv
// s2_share_ctrl: round-robin sharing of one registered 4:1 S2 cell among four requesters.
// Optional burst locking is enabled with macro S2_SHARE_LOCK_EN.
module s2_share_ctrl
  import s2_share_pkg::*;
#(
  parameter int N         = 1,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] lock,
  output logic [NREQ-1:0] gnt,
  output logic            sel_a1,
  output logic            sel_b1,
  output logic            sel_a0,
  output logic            sel_b0,
  output logic            cell_clr,
  output logic            out_vld,
  output idx_t            out_id
);
  state_t          state;
  logic [NREQ-1:0] gnt_q;
  idx_t            idx;
  idx_t            ptr;
  logic [NREQ-1:0] win;
  idx_t            win_idx;
  logic            any;
  logic            unused_ok;
  rr_pick u_pick (
    .req_eff (req & ~gnt_q),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx),
    .any     (any)
  );
`ifdef S2_SHARE_LOCK_EN
  logic [3:0] beat_cnt;
  logic       hold;
  assign hold = (state != IDLE) && |(gnt_q & req & lock) && (beat_cnt < 4'(MAX_BURST));
  assign unused_ok = N[0];
`else
  assign unused_ok = ^{N[0], MAX_BURST[0], lock, state};
`endif
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      gnt_q    <= '0;
      idx      <= '0;
      ptr      <= '0;
      cell_clr <= CELL_CLR_RST;
      out_vld  <= 1'b0;
      out_id   <= '0;
`ifdef S2_SHARE_LOCK_EN
      beat_cnt <= '0;
`endif
    end else begin
      out_vld <= |gnt_q;
      out_id  <= idx;
`ifdef S2_SHARE_LOCK_EN
      if (hold) begin
        state    <= BURST;
        beat_cnt <= beat_cnt + 4'd1;
        cell_clr <= 1'b0;
      end else
`endif
      if (any) begin
        state    <= GRANT;
        gnt_q    <= win;
        idx      <= win_idx;
        ptr      <= win_idx + idx_t'(1);
        cell_clr <= 1'b0;
`ifdef S2_SHARE_LOCK_EN
        beat_cnt <= 4'd1;
`endif
      end else begin
        state    <= IDLE;
        gnt_q    <= '0;
        cell_clr <= 1'b1;
      end
    end
  end
  assign gnt    = gnt_q;
  assign sel_a1 = idx[1];
  assign sel_b1 = idx[1];
  assign sel_a0 = idx[0];
  assign sel_b0 = idx[0];
endmodule

// File: doc/s2_share_ctrl.md
# s2_share_ctrl

Round-robin controller that shares one registered 4:1 logic cell (the S2-style cell: data inputs D0–D3, select S1 = A1|B1, S0 = A0&B0, synchronous clear, output register) among four requesters. It arbitrates requests and drives the cell's A1/B1/A0/B0 select and clear pins. It reports which requester's data is on the cell output one cycle after the cell samples it. It sits beside the cell in the logic-block datapath; requesters drive the cell's D0–D3 directly.

## Interface
- `N`, default 1 — data width; not used by control logic, kept for datapath alignment.
- `MAX_BURST`, default 4 — maximum consecutive beats per grant; only meaningful with `S2_SHARE_LOCK_EN`, legal range 1–15.

Ports (clock and reset first):
- `clk` input 1 — single clock, rising edge.
- `clr` input 1 — asynchronous, active-high reset.
- `req` input 4 — level request, bit i = requester i (drives Di).
- `lock` input 4 — burst hold request, bit i; ignored without `S2_SHARE_LOCK_EN`.
- `gnt` output 4 — one-hot registered grant; high = this cycle is a beat for requester i.
- `sel_a1`, `sel_b1`, `sel_a0`, `sel_b0` output 1 each — cell select pins; `sel_a1 = sel_b1 = idx[1]`, `sel_a0 = sel_b0 = idx[0]`.
- `cell_clr` output 1 — drives the cell's synchronous clear.
- `out_vld` output 1 — cell output holds a granted beat.
- `out_id` output 2 — requester index of that beat.

## Operation
- Eligible set `req_eff = req & ~gnt_q`: the requester granted in the current cycle cannot be regranted at the next edge, except for a locked burst.
- Picker searches from priority pointer `ptr` upward mod 4 (3 wraps to 0); the first eligible bit wins.
- On a grant to i: `gnt_q` = one-hot i, `idx` = i, `ptr` ← (i+1) mod 4.
- `cell_clr` is the registered value of "no grant next cycle", so the cell output is 0 whenever nothing is granted.
- FSM states:
  - `IDLE`: no grant. Goes to `GRANT` if `req_eff` is nonzero.
  - `GRANT`: single beat. Goes to `GRANT` (new winner) if `req_eff` is nonzero, otherwise to `IDLE`. With the macro, goes to `BURST` if `req[i] & lock[i]` for the current winner.
  - `BURST` (macro only): grant held on i while `req[i] & lock[i]` and `beat_cnt < MAX_BURST`. It then falls to normal arbitration with i masked for one decision.
- `beat_cnt` is 4 bits. It counts beats of the current grant, reloads to 1 on a new grant, and saturates at `MAX_BURST`.
- Simultaneous requests: resolved only by `ptr`; there is no fixed priority.
- Requester protocol: present Di while `gnt[i]` is high. Drop `req[i]` at the edge ending that cycle, or keep it high to rearbitrate one cycle later.

## Timing
- Reset values: `gnt` = 0, all `sel_*` = 0, `cell_clr` = 1, `out_vld` = 0, `out_id` = 0, `ptr` = 0, state = `IDLE`, `beat_cnt` = 0.
- `req` sampled at edge k → `gnt`/`sel_*` valid in cycle k+1 → cell registers Di at edge k+1 → `out_vld` = 1 and `out_id` = i in cycle k+2.
- Request-to-data latency is 2 cycles.
- Throughput is one beat per cycle across different requesters.
- A single unlocked requester gets at most one beat every 2 cycles.
- `out_vld`/`out_id` are the 1-cycle delayed copy of `|gnt`/`idx`.
- `clr` asserted mid-operation: all outputs take their reset values immediately, and an in-flight `out_vld` is dropped. The first grant after release comes 1 cycle after the first clock edge that samples a request.

## Configuration
- `S2_SHARE_LOCK_EN` defined: the `lock` input and the `BURST` state are active, with bursts capped at `MAX_BURST` beats.
- Not defined: the `lock` input is ignored, `BURST` and `beat_cnt` are not compiled, and every grant lasts exactly one cycle.

## Structure
- Shared package `s2_share_pkg` holds:
  - `NREQ` = 4;
  - state enum (`IDLE`, `GRANT`, `BURST`);
  - 2-bit index type;
  - reset constant for `cell_clr` (1).
- Sub-module `rr_pick`: combinational; inputs `req_eff[3:0]` and `ptr[1:0]`; outputs one-hot `win`, `win_idx`, and `any`.

## Test plan
- Reset: `clr` = 1 with `req` = 4'b1111 → `gnt` = 0, `cell_clr` = 1, `out_vld` = 0; after release, first `gnt` = 4'b0001.
- `req` = 4'b1111 held → `gnt` sequence 0001, 0010, 0100, 1000, 0001; `out_id` follows 2 cycles after each request sample; `sel_*` pairs match the index.
- Single requester 2 holding `req` → `gnt` = 4'b0100 on alternating cycles; `cell_clr` = 1 in the gap cycles and the cell output is 0 there.
- Pointer wrap: grant to 3, then `req` = 4'b1001 → next grant goes to 0, not 3.
- Macro on, `MAX_BURST` = 4, `req[1]` and `lock[1]` held with `req[0]` high → 4 consecutive `gnt` = 0010, then 0001.
- `clr` pulsed while `out_vld` = 1 → `out_vld` drops without waiting for a clock edge; `ptr` returns to 0.
